// File: rtl/picomips_pkg.sv
// Shared picoMIPS definitions: flow-control opcodes, fetch FSM states and
// the helper that separates flow-control words from ALU words.
package picomips_pkg;

    localparam logic [3:0] OP_JMP   = 4'hA;
    localparam logic [3:0] OP_BEQ   = 4'hB;
    localparam logic [3:0] OP_BNE   = 4'hC;
    localparam logic [3:0] OP_WAITH = 4'hD;
    localparam logic [3:0] OP_WAITL = 4'hE;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        EXEC = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    // Flow-control opcodes occupy the top of the opcode space (A..F).
    function automatic logic is_flow_op(input logic [3:0] opcode);
        return (opcode >= OP_JMP);
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch/branch controller for picoMIPS: a 2-stage fetch/execute pipeline
// that steers the pc through PCincr/Branchaddr and holds the fetched word in IR.
module fetch_ctrl
    import picomips_pkg::*;
#(
    parameter int Psize = 5,
    parameter int Isize = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [Psize-1:0] PCin,
    input  logic [Isize-1:0] Instr,
    input  logic             zflag,
    input  logic             go,
    output logic             PCincr,
    output logic [Psize-1:0] Branchaddr,
    output logic [Isize-1:0] IR,
    output logic             exec_en,
    output logic             stalled,
    output logic             halted
);

    fetch_state_t     state;
    fetch_state_t     stateNext;
    logic [Isize-1:0] irNext;
    logic [3:0]       opcode;
    logic [Psize-1:0] target;
    logic             branchTaken;
    logic             waitHold;
    logic             haltDecode;

    assign opcode = IR[Isize-1 -: 4];
    assign target = IR[Psize-1:0];

    assign branchTaken = (opcode == OP_JMP)
                       || ((opcode == OP_BEQ) && zflag)
                       || ((opcode == OP_BNE) && !zflag);
    assign waitHold    = ((opcode == OP_WAITH) && !go)
                       || ((opcode == OP_WAITL) && go);
    assign haltDecode  = (state == EXEC) && (opcode == OP_HALT);

    // State, instruction register and the sticky halt flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= FILL;
            IR     <= '0;
            halted <= 1'b0;
        end else begin
            state  <= stateNext;
            IR     <= irNext;
            if (haltDecode)
                halted <= 1'b1;
        end
    end

    // A taken branch empties IR so the word fetched behind it is dropped.
    always_comb begin
        stateNext = state;
        irNext    = IR;
        case (state)
            FILL: begin
                stateNext = EXEC;
                irNext    = Instr;
            end
            EXEC: begin
                if (!is_flow_op(opcode)) begin
                    irNext = Instr;
                end else if (branchTaken) begin
                    stateNext = FILL;
                    irNext    = '0;
                end else if (opcode == OP_HALT) begin
                    stateNext = HALT;
                end else if (!waitHold) begin
                    irNext = Instr;
                end
            end
            HALT: begin
                stateNext = HALT;
            end
            default: begin
                stateNext = FILL;
                irNext    = '0;
            end
        endcase
    end

    // Holding the pc is done by branching it to its own address.
    always_comb begin
        PCincr     = 1'b1;
        Branchaddr = PCin;
        exec_en    = 1'b0;
        stalled    = 1'b0;
        case (state)
            EXEC: begin
                if (!is_flow_op(opcode)) begin
                    exec_en = 1'b1;
                end else if (branchTaken) begin
                    PCincr     = 1'b0;
                    Branchaddr = target;
                end else if (opcode == OP_HALT) begin
                    PCincr = 1'b0;
                end else if (waitHold) begin
                    PCincr  = 1'b0;
                    stalled = 1'b1;
                end
            end
            HALT: begin
                PCincr = 1'b0;
            end
            default: begin
                PCincr = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Closed-loop bench: fetch_ctrl driving a behavioural pc and program ROM,
// checked against hand-computed PC/IR/flag values per cycle.
module tb_fetch_ctrl;
    import picomips_pkg::*;

    localparam int PS = 5;
    localparam int IS = 24;

    logic          clk;
    logic          reset;
    logic [PS-1:0] pc;
    logic [IS-1:0] Instr;
    logic          zflag;
    logic          go;
    logic          PCincr;
    logic [PS-1:0] Branchaddr;
    logic [IS-1:0] IR;
    logic          exec_en;
    logic          stalled;
    logic          halted;

    logic [IS-1:0] rom [0:31];

    int total;
    int bad;

    fetch_ctrl #(.Psize(PS), .Isize(IS)) dut (
        .clk        (clk),
        .reset      (reset),
        .PCin       (pc),
        .Instr      (Instr),
        .zflag      (zflag),
        .go         (go),
        .PCincr     (PCincr),
        .Branchaddr (Branchaddr),
        .IR         (IR),
        .exec_en    (exec_en),
        .stalled    (stalled),
        .halted     (halted)
    );

    // Behavioural program counter and asynchronous ROM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pc <= '0;
        else
            pc <= PCincr ? pc + 5'd1 : Branchaddr;
    end

    assign Instr = rom[pc];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [IS-1:0] aluWord(input int i);
        return 24'h100000 + IS'(i);
    endfunction

    function automatic logic [IS-1:0] flowWord(input logic [3:0] op, input logic [PS-1:0] t);
        return {op, 15'd0, t};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic z, input logic g);
        zflag = z;
        go    = g;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic loadAlu();
        for (int i = 0; i < 32; i++)
            rom[i] = aluWord(i);
    endtask

    // Assert reset, check the reset outputs, then release so the next edge is the FILL edge.
    task automatic resetDut();
        reset = 1'b0;
        #1;
        checkOutput("rst_IR", 32'(IR), 32'h0);
        checkOutput("rst_halted", 32'(halted), 32'h0);
        checkOutput("rst_exec_en", 32'(exec_en), 32'h0);
        checkOutput("rst_stalled", 32'(stalled), 32'h0);
        checkOutput("rst_PCincr", 32'(PCincr), 32'h1);
        checkOutput("rst_pc", 32'(pc), 32'h0);
        checkOutput("rst_Branchaddr", 32'(Branchaddr), 32'h0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
    endtask

    task automatic runCond(input logic [3:0] op, input logic z, input logic taken);
        loadAlu();
        rom[0] = flowWord(op, 5'd10);
        applyStimulus(z, 1'b0);
        resetDut();
        step();
        checkOutput("cond_IR", 32'(IR), 32'(flowWord(op, 5'd10)));
        checkOutput("cond_exec_en", 32'(exec_en), 32'h0);
        checkOutput("cond_PCincr", 32'(PCincr), taken ? 32'h0 : 32'h1);
        if (taken)
            checkOutput("cond_target", 32'(Branchaddr), 32'd10);
        step();
        checkOutput("cond_pc", 32'(pc), taken ? 32'd10 : 32'd2);
        checkOutput("cond_exec2", 32'(exec_en), taken ? 32'h0 : 32'h1);
        if (taken) begin
            step();
            checkOutput("cond_IRtgt", 32'(IR), 32'(aluWord(10)));
            checkOutput("cond_pc11", 32'(pc), 32'd11);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0);
        loadAlu();

        // Straight-line ALU execution
        resetDut();
        for (int c = 1; c <= 4; c++) begin
            step();
            checkOutput("line_IR", 32'(IR), 32'(aluWord(c - 1)));
            checkOutput("line_exec_en", 32'(exec_en), 32'h1);
            checkOutput("line_pc", 32'(pc), 32'(c));
        end

        // Unconditional jump with one-cycle bubble
        loadAlu();
        rom[2] = flowWord(OP_JMP, 5'd7);
        resetDut();
        step();
        step();
        step();
        checkOutput("jmp_IR", 32'(IR), 32'(flowWord(OP_JMP, 5'd7)));
        checkOutput("jmp_PCincr", 32'(PCincr), 32'h0);
        checkOutput("jmp_target", 32'(Branchaddr), 32'd7);
        checkOutput("jmp_exec_en", 32'(exec_en), 32'h0);
        step();
        checkOutput("jmp_bubble", 32'(exec_en), 32'h0);
        checkOutput("jmp_flushIR", 32'(IR), 32'h0);
        checkOutput("jmp_pc", 32'(pc), 32'd7);
        step();
        checkOutput("jmp_IR7", 32'(IR), 32'(aluWord(7)));
        checkOutput("jmp_exec7", 32'(exec_en), 32'h1);
        checkOutput("jmp_pc8", 32'(pc), 32'd8);

        // Conditional branches
        runCond(OP_BEQ, 1'b0, 1'b0);
        runCond(OP_BEQ, 1'b1, 1'b1);
        runCond(OP_BNE, 1'b1, 1'b0);
        runCond(OP_BNE, 1'b0, 1'b1);

        // WAITH stalls five cycles until go rises
        loadAlu();
        rom[4] = flowWord(OP_WAITH, 5'd0);
        applyStimulus(1'b0, 1'b0);
        resetDut();
        for (int c = 1; c <= 4; c++)
            step();
        for (int c = 0; c < 5; c++) begin
            step();
            checkOutput("waith_stalled", 32'(stalled), 32'h1);
            checkOutput("waith_pc", 32'(pc), 32'd5);
            checkOutput("waith_PCincr", 32'(PCincr), 32'h0);
            checkOutput("waith_exec_en", 32'(exec_en), 32'h0);
        end
        applyStimulus(1'b0, 1'b1);
        checkOutput("waith_release", 32'(stalled), 32'h0);
        step();
        checkOutput("waith_IR5", 32'(IR), 32'(aluWord(5)));
        checkOutput("waith_stalled0", 32'(stalled), 32'h0);
        checkOutput("waith_pc6", 32'(pc), 32'd6);

        // WAITL with go already low never stalls
        rom[4] = flowWord(OP_WAITL, 5'd0);
        applyStimulus(1'b0, 1'b0);
        resetDut();
        for (int c = 1; c <= 5; c++)
            step();
        checkOutput("waitl_IR", 32'(IR), 32'(flowWord(OP_WAITL, 5'd0)));
        checkOutput("waitl_stalled", 32'(stalled), 32'h0);
        checkOutput("waitl_PCincr", 32'(PCincr), 32'h1);
        step();
        checkOutput("waitl_IR5", 32'(IR), 32'(aluWord(5)));

        // HALT is sticky until reset
        loadAlu();
        rom[6] = flowWord(OP_HALT, 5'd0);
        resetDut();
        for (int c = 1; c <= 7; c++)
            step();
        checkOutput("halt_decode", 32'(halted), 32'h0);
        checkOutput("halt_PCincr", 32'(PCincr), 32'h0);
        checkOutput("halt_hold", 32'(Branchaddr), 32'd7);
        for (int c = 0; c < 20; c++) begin
            step();
            applyStimulus(c[0], c[1]);
            checkOutput("halt_halted", 32'(halted), 32'h1);
            checkOutput("halt_pc", 32'(pc), 32'd7);
            checkOutput("halt_exec_en", 32'(exec_en), 32'h0);
            checkOutput("halt_IR", 32'(IR), 32'(flowWord(OP_HALT, 5'd0)));
        end
        applyStimulus(1'b0, 1'b0);
        resetDut();
        step();
        checkOutput("restart_IR", 32'(IR), 32'(aluWord(0)));
        checkOutput("restart_pc", 32'(pc), 32'd1);
        checkOutput("restart_exec_en", 32'(exec_en), 32'h1);

        // PC wrap from 31 to 0 without a bubble
        loadAlu();
        resetDut();
        for (int c = 1; c <= 33; c++) begin
            step();
            if (c >= 31) begin
                checkOutput("wrap_IR", 32'(IR), 32'(aluWord((c - 1) % 32)));
                checkOutput("wrap_pc", 32'(pc), 32'(c % 32));
                checkOutput("wrap_exec_en", 32'(exec_en), 32'h1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction fetch/branch controller that drives the picoMIPS program counter's PCincr and Branchaddr inputs.
- Reads the asynchronous program ROM at the current PC, latches the word into an instruction register (IR), and decodes flow-control opcodes.
- Forms a 2-stage fetch/execute pipeline: flushes the fetched word on taken branches, and stalls the PC on wait/halt by branching it to itself.

Parameters:
- Psize, 5, PC/address width (must match pc).
- Isize, 24, instruction word width.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-low reset
- PCin  input  Psize  current PC value (pc.PCout; also the ROM address)
- Instr  input  Isize  ROM[PCin], combinational
- zflag  input  1  ALU zero flag, valid in the EXEC cycle
- go  input  1  external handshake, already synchronised to clk
- PCincr  output  1  to pc: 1 = increment, 0 = load Branchaddr
- Branchaddr  output  Psize  to pc: branch or hold address
- IR  output  Isize  instruction register to decoder/ALU
- exec_en  output  1  IR holds a valid non-flow-control instruction this cycle
- stalled  output  1  PC held by a WAIT instruction this cycle
- halted  output  1  HALT executed; sticky until reset

Behaviour:
- Opcode = IR[Isize-1:Isize-4]; branch target = IR[Psize-1:0].
- Opcodes: JMP 4'hA, BEQ 4'hB, BNE 4'hC, WAITH 4'hD, WAITL 4'hE, HALT 4'hF. All other opcodes are ALU ops.
- FSM states: FILL (IR empty), EXEC (IR valid), HALT.
- Reset (async, reset=0): state=FILL, IR=0, halted=0. While in reset, exec_en=0, stalled=0, PCincr=1, Branchaddr=PCin.
- FILL:
  - PCincr=1, Branchaddr=PCin.
  - At the edge: IR<=Instr, state->EXEC.
  - First instruction executes in the cycle after reset release + 1 clock.
- EXEC, by opcode:
  - ALU op: exec_en=1, PCincr=1, IR<=Instr. Stay in EXEC. Throughput is 1 instruction/cycle.
  - JMP, or BEQ with zflag=1, or BNE with zflag=0 (taken): PCincr=0, Branchaddr=target, IR<=0, state->FILL. The word fetched at PC+1 is discarded, giving a 1-cycle bubble. exec_en=0.
  - BEQ/BNE not taken: PCincr=1, IR<=Instr, stay in EXEC. exec_en=0.
  - WAITH with go=0, or WAITL with go=1: stalled=1, PCincr=0, Branchaddr=PCin, IR holds, exec_en=0.
  - WAITH/WAITL once the condition is met: behave as a not-taken branch. If the condition is already met on the first EXEC cycle, there is zero stall.
  - HALT: PCincr=0, Branchaddr=PCin, state->HALT.
- HALT state: halted=1 (registered, asserted from the cycle after HALT is decoded), PCincr=0, Branchaddr=PCin, exec_en=0, IR holds. Only reset exits this state.
- Branch to own address is legal (tight loop). PC wrap from 2^Psize-1 to 0 is handled by pc; the controller ignores it.
- zflag and go are sampled combinationally in EXEC only; they are ignored in FILL and HALT.
- Reset asserted mid-stall or mid-flush returns to FILL immediately with all outputs at reset values.
- Outputs PCincr, Branchaddr, exec_en and stalled are combinational from state, IR and inputs. The IR and state registers are the only flops besides halted.

Decomposition:
- Package picomips_pkg:
  - opcode localparams OP_JMP, OP_BEQ, OP_BNE, OP_WAITH, OP_WAITL, OP_HALT
  - enum fetch_state_t {FILL, EXEC, HALT}
  - function is_flow_op(opcode)
- No sub-module needed. Bench instantiates fetch_ctrl + pc + behavioural ROM array as a closed loop.

Test Plan:
- Straight-line: ROM[0..3]=ALU ops, reset released -> IR=ROM[0] at cycle 1, exec_en=1 on cycles 1..4, PCin=1,2,3,4 at those cycles.
- JMP: ROM[2]=JMP 5'd7 -> at EXEC of ROM[2], PCincr=0, Branchaddr=7. Next cycle exec_en=0 (bubble), PCin=7. Following cycle IR=ROM[7]. ROM[3] never sets exec_en.
- Conditional: BEQ 5'd10 with zflag=0 -> PC continues sequentially. Same with zflag=1 -> PCin=10 after 1 bubble. Repeat for BNE with inverted zflag.
- Handshake: ROM[4]=WAITH, go=0 for 5 cycles then 1 -> stalled=1 for 5 cycles, PCin held at 5. Next IR=ROM[5], stalled=0. WAITL with go held 0 -> zero stall.
- Halt/reset: ROM[6]=HALT -> halted=1 from next cycle, PCin frozen at 7 for 20 cycles. Pulse reset low mid-halt -> halted=0, PCin=0, execution restarts from ROM[0].
- Wrap: Psize=5, ALU ops at 30,31,0 -> PCin wraps 31->0, IR=ROM[0] executes with no bubble.
